ap_ctrl_rr_scheduler: RTL and testbench
=======================================

# ap_ctrl_rr_scheduler

Round-robin scheduler that shares one Bambu-generated kernel (single-cycle start pulse, single-cycle done pulse) among NUM_REQ requesters, each speaking the ap_ctrl_hs protocol. It sits between the requesters' control interfaces and the kernel's start/done ports. It serialises calls, forwards each call's argument word, and returns ready/done/idle per requester. It also reports the latency of the last call and flags spurious kernel completions.

## Interface

- NUM_REQ, 4, number of requesters (2..16)
- ARG_W, 64, width of per-call argument word forwarded to the kernel
- LAT_W, 32, width of the latency counter
- ap_clk  in  1  clock
- ap_rst  in  1  synchronous active-high reset
- req_start  in  NUM_REQ  per-requester ap_start, held high until matching req_ready
- req_arg  in  NUM_REQ*ARG_W  per-requester argument; slice i = bits [i*ARG_W +: ARG_W]
- req_ready  out  NUM_REQ  one-cycle pulse when that requester's call is accepted
- req_done  out  NUM_REQ  one-cycle pulse when that requester's call completes
- req_idle  out  NUM_REQ  requester has no pending and no in-service call
- k_start  out  1  kernel start pulse
- k_arg  out  ARG_W  argument to kernel, stable from ISSUE until completion
- k_done  in  1  kernel done pulse
- busy  out  1  a call is in ISSUE or WAIT
- grant  out  GRANT_W  index of in-service requester; GRANT_W = max(1, clog2(NUM_REQ))
- last_lat  out  LAT_W  cycles from k_start to k_done of the last completed call
- err  out  1  sticky: k_done seen while IDLE

## Operation

- FSM states: IDLE, ISSUE, WAIT.
- IDLE:
  - If any req_start bit is high, pick the first set bit at or after rr_ptr, wrapping modulo NUM_REQ.
  - Latch grant and that requester's arg into k_arg.
  - Go to ISSUE.
  - With no request, stay in IDLE.
- ISSUE (exactly one cycle): k_start=1 and req_ready[grant]=1.
  - If k_done=1 in this cycle, it is the completion (latency 0) and the next state is IDLE.
  - Otherwise the next state is WAIT.
- WAIT: stay until k_done=1, then go to IDLE.
- On completion:
  - Register req_done[grant]=1 for the following cycle.
  - last_lat <= lat_cnt.
  - rr_ptr <= (grant+1) mod NUM_REQ.
- lat_cnt: cleared to 0 in ISSUE; increments by 1 per WAIT cycle and saturates at all-ones.
- req_start seen high after req_ready counts as a new request. That request is served only after the current call returns to IDLE, with normal round-robin priority.
- A requester dropping req_start before req_ready is legal and withdraws its request. No call is issued for a withdrawn request.
- Spurious k_done in IDLE: ignored for sequencing, sets err. err clears only on reset.
- req_idle[i] = ~req_start[i] & ~(busy & grant==i). This is combinational from req_start and registered state.
- k_arg and grant hold their value after completion until the next grant.

## Timing

- Reset (ap_rst=1 at a clock edge) forces:
  - state=IDLE, rr_ptr=0, grant=0, k_arg=0, k_start=0.
  - req_ready=0, req_done=0, last_lat=0, lat_cnt=0, err=0, busy=0.
  - req_idle then follows ~req_start.
- Reset mid-call abandons the call and no req_done is produced. The integrator resets the kernel on the same signal.
- Acceptance latency: req_start sampled in IDLE at cycle t gives k_start and req_ready at t+1.
- Completion latency: k_done at cycle c gives req_done at c+1, with state IDLE at c+1.
- Back-to-back: a new grant can be decided in cycle c+1, giving k_start at c+2. Minimum kernel-to-kernel gap is 2 cycles.
- k_start, req_ready and busy are decoded from the registered state. req_done is registered.
- At most one bit of req_ready and of req_done is high in any cycle.
- rr_ptr wraps from NUM_REQ-1 to 0.

## Structure

- Shared package contents:
  - state encoding (IDLE/ISSUE/WAIT, 2 bits)
  - function for GRANT_W = max(1, clog2(NUM_REQ))
  - LAT_W default constant
- Sub-module rr_pick: combinational round-robin priority encoder.
  - Inputs: req vector, rr_ptr.
  - Outputs: valid, index.
  - Reused by later multi-kernel schedulers.
- Top holds the FSM, argument/grant registers, latency counter and the err flag.

## Test plan

- Single call: req_start[2]=1 at cycle 0 with arg 0xA5; k_done at cycle 5.
  - Required: k_start and req_ready[2] at cycle 1 with k_arg=0xA5.
  - Required: req_done[2] at cycle 6, last_lat=4, busy high in cycles 1..5.
- Contention: req_start[0,1,3] all held high, kernel done 2 cycles after each start.
  - Required: service order 0,1,3,0,…
  - Required: req_idle[3]=0 until its req_done.
- Zero-latency kernel: k_done tied to k_start.
  - Required: ISSUE→IDLE directly, last_lat=0, req_done one cycle after k_start, calls every 2 cycles.
- Wrap and fairness: NUM_REQ=4, rr_ptr=3 after serving 2, requests on 0 and 3.
  - Required: grant 3 first, then 0.
- Spurious done: k_done pulse while IDLE.
  - Required: err=1 and sticky, no req_done, state stays IDLE.
  - Required: next normal call still completes correctly.
- Reset mid-WAIT: ap_rst high for 1 cycle during WAIT of requester 1.
  - Required: all outputs at reset values next cycle, no req_done[1].
  - Required: a held req_start[1] is re-granted from IDLE.

Source files
------------

// File: rtl/ap_ctrl_rr_scheduler_pkg.sv
// Shared definitions for the ap_ctrl round-robin kernel scheduler family:
// FSM encoding, grant index width helper and default latency width.
package ap_ctrl_rr_scheduler_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2
   } sched_state_e;

   localparam int LAT_W_DEF = 32;

   // Index width for n requesters; never narrower than one bit.
   function automatic int grant_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/ap_ctrl_rr_scheduler_rr_pick.sv
// Combinational round-robin priority encoder: first set request bit at or
// after ptr_i, wrapping modulo NUM_REQ.
module ap_ctrl_rr_scheduler_rr_pick #(
   parameter int NUM_REQ = 4,
   parameter int GRANT_W = 2
) (
   input  logic [NUM_REQ-1:0] req_i,
   input  logic [GRANT_W-1:0] ptr_i,
   output logic               valid_o,
   output logic [GRANT_W-1:0] idx_o
);

   localparam logic [GRANT_W:0] NUM_L = (GRANT_W+1)'(NUM_REQ);

   logic [2*NUM_REQ-1:0] dbl;
   logic [NUM_REQ-1:0]   rot;
   logic [GRANT_W-1:0]   off;
   logic [GRANT_W:0]     sum;

   // Bit k of rot is request (ptr_i + k) mod NUM_REQ.
   assign dbl = {req_i, req_i};
   assign rot = NUM_REQ'(dbl >> ptr_i);

   always_comb begin
      valid_o = |req_i;
      off     = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         if (rot[k]) off = GRANT_W'(k);
      end
      sum   = {1'b0, ptr_i} + {1'b0, off};
      idx_o = (sum >= NUM_L) ? GRANT_W'(sum - NUM_L) : GRANT_W'(sum);
   end

endmodule

// File: rtl/ap_ctrl_rr_scheduler.sv
// Shares one start/done kernel among NUM_REQ ap_ctrl_hs requesters with
// round-robin arbitration, call latency reporting and a spurious-done flag.
module ap_ctrl_rr_scheduler
   import ap_ctrl_rr_scheduler_pkg::*;
#(
   parameter  int NUM_REQ = 4,
   parameter  int ARG_W   = 64,
   parameter  int LAT_W   = LAT_W_DEF,
   localparam int GRANT_W = grant_w(NUM_REQ)
) (
   input  logic                     ap_clk,
   input  logic                     ap_rst,
   input  logic [NUM_REQ-1:0]       req_start,
   input  logic [NUM_REQ*ARG_W-1:0] req_arg,
   output logic [NUM_REQ-1:0]       req_ready,
   output logic [NUM_REQ-1:0]       req_done,
   output logic [NUM_REQ-1:0]       req_idle,
   output logic                     k_start,
   output logic [ARG_W-1:0]         k_arg,
   input  logic                     k_done,
   output logic                     busy,
   output logic [GRANT_W-1:0]       grant,
   output logic [LAT_W-1:0]         last_lat,
   output logic                     err,
   output logic [1:0]               dbg_state
);

   sched_state_e        state_q, state_d;
   logic [GRANT_W-1:0]  rr_ptr_q, rr_ptr_d;
   logic [GRANT_W-1:0]  grant_q, grant_d;
   logic [ARG_W-1:0]    k_arg_q, k_arg_d;
   logic [LAT_W-1:0]    lat_cnt_q, lat_cnt_d;
   logic [LAT_W-1:0]    last_lat_q, last_lat_d;
   logic                err_q, err_d;
   logic [NUM_REQ-1:0]  req_done_q, req_done_d;

   logic                pick_valid;
   logic [GRANT_W-1:0]  pick_idx;
   logic [NUM_REQ-1:0]  grant_oh;
   logic                completion;

   ap_ctrl_rr_scheduler_rr_pick #(
      .NUM_REQ (NUM_REQ),
      .GRANT_W (GRANT_W)
   ) u_pick (
      .req_i   (req_start),
      .ptr_i   (rr_ptr_q),
      .valid_o (pick_valid),
      .idx_o   (pick_idx)
   );

   assign grant_oh   = NUM_REQ'(1) << grant_q;
   assign completion = (state_q != ST_IDLE) && k_done;

   always_ff @(posedge ap_clk) begin
      if (ap_rst) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (pick_valid) state_d = ST_ISSUE;
         ST_ISSUE: state_d = k_done ? ST_IDLE : ST_WAIT;
         ST_WAIT:  if (k_done) state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      k_start   = (state_q == ST_ISSUE);
      busy      = (state_q != ST_IDLE);
      req_ready = (state_q == ST_ISSUE) ? grant_oh : '0;
      req_idle  = ~req_start & ~(busy ? grant_oh : '0);
      req_done  = req_done_q;
      grant     = grant_q;
      k_arg     = k_arg_q;
      last_lat  = last_lat_q;
      err       = err_q;
      dbg_state = state_q;
   end

   // A completing WAIT cycle still counts, so last_lat spans k_start to k_done.
   always_comb begin
      grant_d    = grant_q;
      k_arg_d    = k_arg_q;
      lat_cnt_d  = lat_cnt_q;
      rr_ptr_d   = rr_ptr_q;
      last_lat_d = last_lat_q;
      req_done_d = '0;
      err_d      = err_q | ((state_q == ST_IDLE) && k_done);
      if ((state_q == ST_IDLE) && pick_valid) begin
         grant_d = pick_idx;
         k_arg_d = req_arg[pick_idx*ARG_W +: ARG_W];
      end
      if (state_q == ST_ISSUE) begin
         lat_cnt_d = '0;
      end else if (state_q == ST_WAIT) begin
         lat_cnt_d = (lat_cnt_q == '1) ? lat_cnt_q : lat_cnt_q + LAT_W'(1);
      end
      if (completion) begin
         req_done_d = grant_oh;
         last_lat_d = lat_cnt_d;
         rr_ptr_d   = (grant_q == GRANT_W'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
      end
   end

   always_ff @(posedge ap_clk) begin
      if (ap_rst) begin
         rr_ptr_q   <= '0;
         grant_q    <= '0;
         k_arg_q    <= '0;
         lat_cnt_q  <= '0;
         last_lat_q <= '0;
         err_q      <= 1'b0;
         req_done_q <= '0;
      end else begin
         rr_ptr_q   <= rr_ptr_d;
         grant_q    <= grant_d;
         k_arg_q    <= k_arg_d;
         lat_cnt_q  <= lat_cnt_d;
         last_lat_q <= last_lat_d;
         err_q      <= err_d;
         req_done_q <= req_done_d;
      end
   end

endmodule

// File: tb/tb_ap_ctrl_rr_scheduler.sv
// Directed cycle-table bench for ap_ctrl_rr_scheduler with NUM_REQ=4.
module tb_ap_ctrl_rr_scheduler;

   localparam int N  = 4;
   localparam int AW = 64;
   localparam int LW = 32;

   logic            ap_clk;
   logic            ap_rst;
   logic [N-1:0]    req_start;
   logic [N*AW-1:0] req_arg;
   logic [N-1:0]    req_ready;
   logic [N-1:0]    req_done;
   logic [N-1:0]    req_idle;
   logic            k_start;
   logic [AW-1:0]   k_arg;
   logic            k_done;
   logic            busy;
   logic [1:0]      grant;
   logic [LW-1:0]   last_lat;
   logic            err;
   logic [1:0]      dbg_state;

   int checks = 0;
   int errors = 0;

   ap_ctrl_rr_scheduler #(.NUM_REQ(N), .ARG_W(AW), .LAT_W(LW)) dut (
      .ap_clk    (ap_clk),
      .ap_rst    (ap_rst),
      .req_start (req_start),
      .req_arg   (req_arg),
      .req_ready (req_ready),
      .req_done  (req_done),
      .req_idle  (req_idle),
      .k_start   (k_start),
      .k_arg     (k_arg),
      .k_done    (k_done),
      .busy      (busy),
      .grant     (grant),
      .last_lat  (last_lat),
      .err       (err),
      .dbg_state (dbg_state)
   );

   initial ap_clk = 1'b0;
   always #5 ap_clk = ~ap_clk;

   typedef struct {
      logic         rst;
      logic [N-1:0] start;
      logic         kd;
      logic         kst;
      logic [N-1:0] rdy;
      logic [N-1:0] dn;
      logic         bsy;
      logic [1:0]   gnt;
      logic [N-1:0] idle;
      logic [LW-1:0] lat;
      logic         er;
      int           karg;
   } row_t;

   row_t rows[$];

   function automatic logic [AW-1:0] arg_of(input int i);
      logic [AW-1:0] a;
      a = 64'hA3 + AW'(i) + (AW'(i) << 48);
      return a;
   endfunction

   task automatic add(input logic rst, input logic [N-1:0] start, input logic kd,
                      input logic kst, input logic [N-1:0] rdy, input logic [N-1:0] dn,
                      input logic bsy, input logic [1:0] gnt, input logic [N-1:0] idle,
                      input int lat, input logic er, input int karg);
      row_t r;
      r.rst = rst; r.start = start; r.kd = kd; r.kst = kst; r.rdy = rdy; r.dn = dn;
      r.bsy = bsy; r.gnt = gnt; r.idle = idle; r.lat = LW'(lat); r.er = er; r.karg = karg;
      rows.push_back(r);
   endtask

   task automatic chk(input string nm, input logic [AW-1:0] act, input logic [AW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Inputs change just after the falling edge; outputs are sampled 1ns later.
   task automatic drive(input logic rst, input logic [N-1:0] start, input logic kd);
      @(negedge ap_clk);
      ap_rst    = rst;
      req_start = start;
      k_done    = kd;
      #1;
   endtask

   task automatic check_row(input string t, input row_t r);
      chk({t, " k_start"},   AW'(k_start),   AW'(r.kst));
      chk({t, " req_ready"}, AW'(req_ready), AW'(r.rdy));
      chk({t, " req_done"},  AW'(req_done),  AW'(r.dn));
      chk({t, " busy"},      AW'(busy),      AW'(r.bsy));
      chk({t, " grant"},     AW'(grant),     AW'(r.gnt));
      chk({t, " req_idle"},  AW'(req_idle),  AW'(r.idle));
      chk({t, " last_lat"},  AW'(last_lat),  AW'(r.lat));
      chk({t, " err"},       AW'(err),       AW'(r.er));
      chk({t, " k_arg"},     k_arg,          (r.karg < 0) ? '0 : arg_of(r.karg));
   endtask

   initial begin
      ap_rst    = 1'b1;
      req_start = '0;
      k_done    = 1'b0;
      for (int i = 0; i < N; i++) req_arg[i*AW +: AW] = arg_of(i);

      // Single call on requester 2, done at cycle 5.
      add(0, 4'b0100, 0, 0, 4'b0000, 4'b0000, 0, 0, 4'b1011, 0, 0, -1);
      add(0, 4'b0100, 0, 1, 4'b0100, 4'b0000, 1, 2, 4'b1011, 0, 0, 2);
      add(0, 4'b0000, 0, 0, 4'b0000, 4'b0000, 1, 2, 4'b1011, 0, 0, 2);
      add(0, 4'b0000, 0, 0, 4'b0000, 4'b0000, 1, 2, 4'b1011, 0, 0, 2);
      add(0, 4'b0000, 0, 0, 4'b0000, 4'b0000, 1, 2, 4'b1011, 0, 0, 2);
      add(0, 4'b0000, 1, 0, 4'b0000, 4'b0000, 1, 2, 4'b1011, 0, 0, 2);
      add(0, 4'b0000, 0, 0, 4'b0000, 4'b0100, 0, 2, 4'b1111, 4, 0, 2);
      // Wrap: pointer is 3, requests on 0 and 3 -> 3 first, then 0.
      add(0, 4'b1001, 0, 0, 4'b0000, 4'b0000, 0, 2, 4'b0110, 4, 0, 2);
      add(0, 4'b1001, 0, 1, 4'b1000, 4'b0000, 1, 3, 4'b0110, 4, 0, 3);
      add(0, 4'b0001, 1, 0, 4'b0000, 4'b0000, 1, 3, 4'b0110, 4, 0, 3);
      add(0, 4'b0001, 0, 0, 4'b0000, 4'b1000, 0, 3, 4'b1110, 1, 0, 3);
      add(0, 4'b0001, 0, 1, 4'b0001, 4'b0000, 1, 0, 4'b1110, 1, 0, 0);
      add(0, 4'b0000, 1, 0, 4'b0000, 4'b0000, 1, 0, 4'b1110, 1, 0, 0);
      add(0, 4'b0000, 0, 0, 4'b0000, 4'b0001, 0, 0, 4'b1111, 1, 0, 0);
      // Reset so contention starts from pointer 0.
      add(1, 4'b0000, 0, 0, 4'b0000, 4'b0000, 0, 0, 4'b1111, 1, 0, 0);
      // Contention 0,1,3 held; kernel done two cycles after each start.
      add(0, 4'b1011, 0, 0, 4'b0000, 4'b0000, 0, 0, 4'b0100, 0, 0, -1);
      add(0, 4'b1011, 0, 1, 4'b0001, 4'b0000, 1, 0, 4'b0100, 0, 0, 0);
      add(0, 4'b1011, 0, 0, 4'b0000, 4'b0000, 1, 0, 4'b0100, 0, 0, 0);
      add(0, 4'b1011, 1, 0, 4'b0000, 4'b0000, 1, 0, 4'b0100, 0, 0, 0);
      add(0, 4'b1011, 0, 0, 4'b0000, 4'b0001, 0, 0, 4'b0100, 2, 0, 0);
      add(0, 4'b1011, 0, 1, 4'b0010, 4'b0000, 1, 1, 4'b0100, 2, 0, 1);
      add(0, 4'b1011, 0, 0, 4'b0000, 4'b0000, 1, 1, 4'b0100, 2, 0, 1);
      add(0, 4'b1011, 1, 0, 4'b0000, 4'b0000, 1, 1, 4'b0100, 2, 0, 1);
      add(0, 4'b1011, 0, 0, 4'b0000, 4'b0010, 0, 1, 4'b0100, 2, 0, 1);
      add(0, 4'b1011, 0, 1, 4'b1000, 4'b0000, 1, 3, 4'b0100, 2, 0, 3);
      add(0, 4'b1011, 0, 0, 4'b0000, 4'b0000, 1, 3, 4'b0100, 2, 0, 3);
      add(0, 4'b1011, 1, 0, 4'b0000, 4'b0000, 1, 3, 4'b0100, 2, 0, 3);
      add(0, 4'b1011, 0, 0, 4'b0000, 4'b1000, 0, 3, 4'b0100, 2, 0, 3);
      add(0, 4'b1011, 0, 1, 4'b0001, 4'b0000, 1, 0, 4'b0100, 2, 0, 0);
      add(0, 4'b0000, 1, 0, 4'b0000, 4'b0000, 1, 0, 4'b1110, 2, 0, 0);
      add(0, 4'b0000, 0, 0, 4'b0000, 4'b0001, 0, 0, 4'b1111, 1, 0, 0);
      // Zero-latency kernel: k_done coincides with k_start.
      add(0, 4'b0010, 0, 0, 4'b0000, 4'b0000, 0, 0, 4'b1101, 1, 0, 0);
      add(0, 4'b0010, 1, 1, 4'b0010, 4'b0000, 1, 1, 4'b1101, 1, 0, 1);
      add(0, 4'b0010, 0, 0, 4'b0000, 4'b0010, 0, 1, 4'b1101, 0, 0, 1);
      add(0, 4'b0010, 1, 1, 4'b0010, 4'b0000, 1, 1, 4'b1101, 0, 0, 1);
      add(0, 4'b0000, 0, 0, 4'b0000, 4'b0010, 0, 1, 4'b1111, 0, 0, 1);

      repeat (2) @(negedge ap_clk);
      foreach (rows[i]) begin
         drive(rows[i].rst, rows[i].start, rows[i].kd);
         check_row($sformatf("c%0d", i), rows[i]);
      end

      // Spurious k_done in IDLE: err sets and sticks, sequencing unaffected.
      drive(0, 4'b0000, 1);
      chk("spur err_before", AW'(err), 0);
      drive(0, 4'b0000, 0);
      chk("spur err", AW'(err), 1);
      chk("spur req_done", AW'(req_done), 0);
      chk("spur state", AW'(dbg_state), 0);
      chk("spur busy", AW'(busy), 0);
      drive(0, 4'b0100, 0);
      chk("spur err_sticky", AW'(err), 1);
      drive(0, 4'b0100, 0);
      chk("spur2 ready", AW'(req_ready), 4'b0100);
      chk("spur2 k_arg", k_arg, arg_of(2));
      drive(0, 4'b0000, 0);
      chk("spur2 state_wait", AW'(dbg_state), 2);
      drive(0, 4'b0000, 1);
      drive(0, 4'b0000, 0);
      chk("spur2 req_done", AW'(req_done), 4'b0100);
      chk("spur2 last_lat", AW'(last_lat), 2);
      chk("spur2 err", AW'(err), 1);

      // Reset during WAIT of requester 1 with its req_start held.
      drive(0, 4'b0010, 0);
      drive(0, 4'b0010, 0);
      chk("rst ready1", AW'(req_ready), 4'b0010);
      drive(0, 4'b0010, 0);
      chk("rst in_wait", AW'(dbg_state), 2);
      drive(1, 4'b0010, 0);
      drive(0, 4'b0010, 0);
      chk("rst state", AW'(dbg_state), 0);
      chk("rst k_start", AW'(k_start), 0);
      chk("rst req_ready", AW'(req_ready), 0);
      chk("rst req_done", AW'(req_done), 0);
      chk("rst busy", AW'(busy), 0);
      chk("rst grant", AW'(grant), 0);
      chk("rst k_arg", k_arg, 0);
      chk("rst last_lat", AW'(last_lat), 0);
      chk("rst err", AW'(err), 0);
      chk("rst req_idle", AW'(req_idle), 4'b1101);
      drive(0, 4'b0010, 0);
      chk("regrant k_start", AW'(k_start), 1);
      chk("regrant ready", AW'(req_ready), 4'b0010);
      chk("regrant grant", AW'(grant), 1);
      chk("regrant k_arg", k_arg, arg_of(1));
      chk("regrant req_done", AW'(req_done), 0);
      drive(0, 4'b0000, 1);
      drive(0, 4'b0000, 0);
      chk("regrant done", AW'(req_done), 4'b0010);
      chk("regrant last_lat", AW'(last_lat), 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
